// File: rtl/alu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// alu_pipe_pkg
// Shared definitions for the two-stage ALU datapath:
//   alu_op_e  - 3-bit ALU operation encoding driven on alu_ctrl
//   REG_ZERO  - index of the hardwired-zero register
// ---------------------------------------------------------------------------
package alu_pipe_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5,
      ALU_SLL = 3'd6,
      ALU_SRL = 3'd7
   } alu_op_e;

   localparam int unsigned REG_ZERO = 0;

   // op2 comes from the RS2 read port only when alu_src selects the register
   function automatic logic uses_rs2(input logic alu_src);
      return !alu_src;
   endfunction

endpackage

// File: rtl/alu_pipe_regfile.sv
// ---------------------------------------------------------------------------
// alu_pipe_regfile
// 2**ADDR_WIDTH x DATA_WIDTH register file, register REG_ZERO hardwired to 0.
// Ports:
//   clk, rst             clock, async active-high reset (clears every entry)
//   i_raddr1/o_rdata1    async read port 1
//   i_raddr2/o_rdata2    async read port 2
//   i_we/i_waddr/i_wdata sync write port (writes to REG_ZERO are dropped)
//   o_a0                 live contents of register A0_ADDR
// ---------------------------------------------------------------------------
module alu_pipe_regfile
   import alu_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int A0_ADDR    = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] i_raddr1,
   output logic [DATA_WIDTH-1:0] o_rdata1,
   input  logic [ADDR_WIDTH-1:0] i_raddr2,
   output logic [DATA_WIDTH-1:0] o_rdata2,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_a0
);

   localparam int              NREG     = 2 ** ADDR_WIDTH;
   localparam [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);
   localparam [ADDR_WIDTH-1:0] A0_IDX   = ADDR_WIDTH'(A0_ADDR);

   logic [DATA_WIDTH-1:0] r_mem [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we && (i_waddr != ZERO_IDX)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = (i_raddr1 == ZERO_IDX) ? '0 : r_mem[i_raddr1];
   assign o_rdata2 = (i_raddr2 == ZERO_IDX) ? '0 : r_mem[i_raddr2];
   assign o_a0     = (A0_IDX == ZERO_IDX)   ? '0 : r_mem[A0_IDX];

endmodule

// File: rtl/alu_pipe_datapath.sv
// ---------------------------------------------------------------------------
// alu_pipe_datapath
// Two-stage (issue / execute) register-file + ALU datapath.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid / in_ready   issue handshake
//   alu_ctrl, alu_src     operation and op2 select (1: imm, 0: RS2 data)
//   rs1, rs2, rd, we, imm register addresses, write enable, immediate
//   out_valid             one-cycle pulse per retired op
//   alu_out, zero         registered result and result==0 flag
//   a0                    contents of register A0_ADDR
// Build option:
//   ALU_PIPE_FWD_EN  defined   -> EX result bypassed to IS operands, no stall
//                    undefined -> one-cycle stall on a read-after-write hazard
// ---------------------------------------------------------------------------
module alu_pipe_datapath
   import alu_pipe_pkg::*;
#(
   parameter int DATA_WIDTH          = 32,
   parameter int REG_FILE_ADDR_WIDTH = 5,
   parameter int A0_ADDR             = 10
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [2:0]                     alu_ctrl,
   input  logic                           alu_src,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] rs1,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] rs2,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] rd,
   input  logic                           we,
   input  logic [DATA_WIDTH-1:0]          imm,
   output logic                           out_valid,
   output logic [DATA_WIDTH-1:0]          alu_out,
   output logic                           zero,
   output logic [DATA_WIDTH-1:0]          a0
);

   localparam int                       SHW      = $clog2(DATA_WIDTH);
   localparam [REG_FILE_ADDR_WIDTH-1:0] ZERO_IDX = REG_FILE_ADDR_WIDTH'(REG_ZERO);

   // Field widths follow the module parameters, so the stage record is
   // declared here rather than in the package.
   typedef struct packed {
      logic [DATA_WIDTH-1:0]          op1;
      logic [DATA_WIDTH-1:0]          op2;
      alu_op_e                        ctrl;
      logic [REG_FILE_ADDR_WIDTH-1:0] rd;
      logic                           we;
      logic                           valid;
   } ex_stage_t;

   ex_stage_t             r_ex;
   logic [DATA_WIDTH-1:0] r_alu_out;
   logic                  r_zero;
   logic                  r_out_valid;

   logic [DATA_WIDTH-1:0] w_rdata1;
   logic [DATA_WIDTH-1:0] w_rdata2;
   logic [DATA_WIDTH-1:0] w_op1;
   logic [DATA_WIDTH-1:0] w_op2;
   logic [DATA_WIDTH-1:0] w_alu_res;
   logic                  w_ex_writes;
   logic                  w_dep1;
   logic                  w_dep2;
   logic                  w_accept;
   logic                  w_rf_we;

   alu_pipe_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (REG_FILE_ADDR_WIDTH),
      .A0_ADDR    (A0_ADDR)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .i_raddr1 (rs1),
      .o_rdata1 (w_rdata1),
      .i_raddr2 (rs2),
      .o_rdata2 (w_rdata2),
      .i_we     (w_rf_we),
      .i_waddr  (r_ex.rd),
      .i_wdata  (w_alu_res),
      .o_a0     (a0)
   );

   // Read-after-write dependency between the EX writer and the IS reader.
   // A register only counts as read through rs2 when op2 selects it.
   assign w_ex_writes = r_ex.valid && r_ex.we && (r_ex.rd != ZERO_IDX);
   assign w_dep1      = w_ex_writes && (rs1 == r_ex.rd);
   assign w_dep2      = w_ex_writes && uses_rs2(alu_src) && (rs2 == r_ex.rd);

`ifdef ALU_PIPE_FWD_EN
   assign in_ready = !rst;
   assign w_op1    = w_dep1 ? w_alu_res : w_rdata1;
   assign w_op2    = alu_src ? imm : (w_dep2 ? w_alu_res : w_rdata2);
`else
   // Holding the op for one cycle lets the EX write land in the register
   // file; the next cycle sees an empty EX stage and so no hazard.
   assign in_ready = !rst && !(in_valid && (w_dep1 || w_dep2));
   assign w_op1    = w_rdata1;
   assign w_op2    = alu_src ? imm : w_rdata2;
`endif

   assign w_accept = in_valid && in_ready;
   assign w_rf_we  = r_ex.valid && r_ex.we;

   always_comb begin
      w_alu_res = '0;
      case (r_ex.ctrl)
         ALU_ADD: w_alu_res = r_ex.op1 + r_ex.op2;
         ALU_SUB: w_alu_res = r_ex.op1 - r_ex.op2;
         ALU_AND: w_alu_res = r_ex.op1 & r_ex.op2;
         ALU_OR:  w_alu_res = r_ex.op1 | r_ex.op2;
         ALU_XOR: w_alu_res = r_ex.op1 ^ r_ex.op2;
         ALU_SLT: w_alu_res = {{(DATA_WIDTH-1){1'b0}},
                               ($signed(r_ex.op1) < $signed(r_ex.op2))};
         ALU_SLL: w_alu_res = r_ex.op1 << r_ex.op2[SHW-1:0];
         ALU_SRL: w_alu_res = r_ex.op1 >> r_ex.op2[SHW-1:0];
         default: w_alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex        <= '0;
         r_alu_out   <= '0;
         r_zero      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         // No accept means a bubble enters EX
         r_ex.valid <= w_accept;
         if (w_accept) begin
            r_ex.op1  <= w_op1;
            r_ex.op2  <= w_op2;
            r_ex.ctrl <= alu_op_e'(alu_ctrl);
            r_ex.rd   <= rd;
            r_ex.we   <= we;
         end
         r_out_valid <= r_ex.valid;
         if (r_ex.valid) begin
            r_alu_out <= w_alu_res;
            r_zero    <= (w_alu_res == '0);
         end
      end
   end

   assign out_valid = r_out_valid;
   assign alu_out   = r_alu_out;
   assign zero      = r_zero;

endmodule

// File: tb/tb_alu_pipe_datapath.sv
module tb_alu_pipe_datapath;
   import alu_pipe_pkg::*;

`ifdef ALU_PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  alu_ctrl;
   logic        alu_src;
   logic [4:0]  rs1, rs2, rd;
   logic        we;
   logic [31:0] imm;
   logic        out_valid;
   logic [31:0] alu_out;
   logic        zero;
   logic [31:0] a0;

   alu_pipe_datapath #(
      .DATA_WIDTH          (32),
      .REG_FILE_ADDR_WIDTH (5),
      .A0_ADDR             (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .alu_src   (alu_src),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd        (rd),
      .we        (we),
      .imm       (imm),
      .out_valid (out_valid),
      .alu_out   (alu_out),
      .zero      (zero),
      .a0        (a0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  ctrl;
      logic        src;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] imm;
      logic [31:0] exp_out;
      logic        exp_zero;
      int          hz;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] q_out [$];
   logic        q_zero [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   function automatic vec_t mk(input logic [2:0] c, input logic s, input logic [4:0] a,
                               input logic [4:0] b, input logic [4:0] d, input logic w,
                               input logic [31:0] im, input logic [31:0] eo,
                               input logic ez, input int hz);
      vec_t v;
      v.ctrl = c; v.src = s; v.rs1 = a; v.rs2 = b; v.rd = d; v.we = w;
      v.imm = im; v.exp_out = eo; v.exp_zero = ez; v.hz = hz;
      return v;
   endfunction

   // Drive one op from a negedge, wait (bounded) for in_ready, return stall cycles.
   task automatic issue(input vec_t v, input bit expect_retire, output int stalls);
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = v.ctrl; alu_src = v.src;
      rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; we = v.we; imm = v.imm;
      #1;
      stalls = 0;
      while (!in_ready && stalls < 4) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      if (!in_ready) begin
         n_checks++;
         $display("FAIL issue_timeout: in_ready stuck at %0b for rd=%0d", in_ready, v.rd);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         if (expect_retire) begin
            q_out.push_back(v.exp_out);
            q_zero.push_back(v.exp_zero);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   // Retire monitor: each out_valid pulse must match the oldest accepted op.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q_out.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_retire: out_valid=1 alu_out=0x%08h with nothing pending", alu_out);
         end else begin
            chk("retire_alu_out", alu_out, q_out.pop_front());
            chk("retire_zero", {31'd0, zero}, {31'd0, q_zero.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   vec_t vecs [21];
   int   st;

   initial begin
      vecs[0]  = mk(ALU_ADD, 1, 0, 0, 1,  1, 32'd5,          32'd5,          0, 0);
      vecs[1]  = mk(ALU_ADD, 1, 0, 0, 2,  1, 32'd7,          32'd7,          0, 0);
      vecs[2]  = mk(ALU_SUB, 0, 2, 2, 3,  1, 32'd0,          32'd0,          1, 1);
      vecs[3]  = mk(ALU_ADD, 1, 0, 0, 4,  1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0);
      vecs[4]  = mk(ALU_ADD, 1, 0, 0, 5,  1, 32'd1,          32'd1,          0, 0);
      vecs[5]  = mk(ALU_SLT, 0, 4, 5, 6,  1, 32'd0,          32'd1,          0, 1);
      vecs[6]  = mk(ALU_ADD, 1, 0, 0, 7,  1, 32'h8000_0000,  32'h8000_0000,  0, 0);
      vecs[7]  = mk(ALU_SRL, 1, 7, 0, 8,  1, 32'd31,         32'd1,          0, 1);
      vecs[8]  = mk(ALU_ADD, 1, 0, 0, 9,  1, 32'd1,          32'd1,          0, 0);
      vecs[9]  = mk(ALU_SLL, 1, 9, 0, 11, 1, 32'd33,         32'd2,          0, 1);
      vecs[10] = mk(ALU_AND, 1, 4, 0, 12, 1, 32'h0000_0F0F,  32'h0000_0F0F,  0, 0);
      vecs[11] = mk(ALU_OR,  0, 1, 2, 13, 1, 32'd0,          32'd7,          0, 0);
      vecs[12] = mk(ALU_XOR, 0, 1, 2, 14, 1, 32'd0,          32'd2,          0, 0);
      vecs[13] = mk(ALU_ADD, 1, 0, 0, 0,  1, 32'd9,          32'd9,          0, 0);
      vecs[14] = mk(ALU_ADD, 0, 0, 0, 15, 1, 32'd0,          32'd0,          1, 0);
      vecs[15] = mk(ALU_SUB, 1, 0, 0, 16, 1, 32'd5,          32'hFFFF_FFFB,  0, 0);
      vecs[16] = mk(ALU_ADD, 1, 4, 0, 17, 1, 32'd1,          32'd0,          1, 0);
      vecs[17] = mk(ALU_SLT, 0, 5, 4, 18, 1, 32'd0,          32'd0,          1, 0);
      vecs[18] = mk(ALU_SLL, 1, 5, 0, 19, 0, 32'd4,          32'd16,         0, 0);
      vecs[19] = mk(ALU_ADD, 1, 19, 0, 20, 1, 32'd0,         32'd0,          1, 0);
      vecs[20] = mk(ALU_ADD, 1, 1, 20, 22, 1, 32'd2,         32'd7,          0, 0);

      rst = 1'b1; in_valid = 1'b0; alu_ctrl = 3'd0; alu_src = 1'b0;
      rs1 = '0; rs2 = '0; rd = '0; we = 1'b0; imm = '0;

      @(negedge clk);
      chk("reset_in_ready",  {31'd0, in_ready},  32'd0);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_alu_out",   alu_out,            32'd0);
      chk("reset_zero",      {31'd0, zero},      32'd0);
      chk("reset_a0",        a0,                 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 21; i++) begin
         issue(vecs[i], 1'b1, st);
         chk($sformatf("stall_cycles_v%0d", i), st, FWD ? 32'd0 : 32'(vecs[i].hz));
      end
      idle(1);
      #1;
      chk("a0_untouched", a0, 32'd0);

      // Dependent chain on x10 (mirrored on a0)
      issue(mk(ALU_ADD, 1, 0, 0, 10, 1, 32'd3, 32'd3, 0, 0), 1'b1, st);
      chk("chain_first_stall", st, 32'd0);
      issue(mk(ALU_ADD, 0, 10, 10, 10, 1, 32'd0, 32'd6, 0, 1), 1'b1, st);
      chk("chain_dep_stall", st, FWD ? 32'd0 : 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("chain_a0_mid", a0, 32'd3);
      chk("chain_idle_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      #1;
      chk("chain_a0_final", a0, 32'd6);

      // Bubble: no retire, result holds
      @(negedge clk);
      #1;
      chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
      chk("bubble_alu_hold",  alu_out,            32'd6);
      chk("bubble_zero_hold", {31'd0, zero},      32'd0);

      // Reset with an op in EX: discarded, no write
      issue(mk(ALU_ADD, 1, 0, 0, 10, 1, 32'd4, 32'd4, 0, 0), 1'b0, st);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_a0",        a0,                 32'd0);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_in_ready",  {31'd0, in_ready},  32'd0);
      chk("midrst_alu_out",   alu_out,            32'd0);
      @(negedge clk);
      #1;
      chk("midrst_hold_in_ready",  {31'd0, in_ready},  32'd0);
      chk("midrst_hold_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_release_ready", {31'd0, in_ready}, 32'd1);
      idle(2);
      #1;
      chk("midrst_a0_after", a0, 32'd0);
      issue(mk(ALU_ADD, 1, 10, 0, 23, 1, 32'd0, 32'd0, 1, 0), 1'b1, st);
      issue(mk(ALU_ADD, 1, 1,  0, 24, 1, 32'd0, 32'd0, 1, 0), 1'b1, st);
      idle(4);

      chk("pending_drained", 32'(q_out.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
